alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand/result width.
REQ-002 Parameter OP_WIDTH, default 12, one-hot ALU opcode width (bits 0..11 = add, sub, and, or, nor, xor, slt, sltu, sll, srl, sra, lui).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 resetn  input  1  reset, asynchronous, active-low.
REQ-005 req0_valid / req1_valid  input  1  requester n has an operation pending.
REQ-006 req0_ready / req1_ready  output  1  requester n's operation is accepted this cycle.
REQ-007 req0_A, req0_B / req1_A, req1_B  input  DATA_WIDTH  operands of requester n.
REQ-008 req0_ALUop / req1_ALUop  input  OP_WIDTH  one-hot opcode of requester n.
REQ-009 rsp_valid  output  1  response register holds a result.
REQ-010 rsp_ready  input  1  consumer takes the response this cycle.
REQ-011 rsp_id  output  1  index of the requester that issued the response.
REQ-012 rsp_result  output  DATA_WIDTH  ALU Result.
REQ-013 rsp_zero / rsp_overflow / rsp_carryout  output  1  ALU Zero, Overflow and CarryOut flags.
REQ-014 rsp_err  output  1  illegal-opcode flag (see Configuration).

Function
REQ-015 The block SHALL time-share one ALU instance between two requesters; at most one request is accepted per cycle.
REQ-016 slot_free SHALL equal (!rsp_valid || rsp_ready); no request is accepted when slot_free is 0.
REQ-017 With exactly one reqN_valid high and slot_free high, reqN_ready SHALL be 1, regardless of priority state.
REQ-018 With both valid and slot_free high, grant SHALL go to the port other than last_grant (round-robin).
REQ-019 last_grant SHALL update to the accepted port only on a cycle with reqN_valid && reqN_ready.
REQ-020 reqN_ready SHALL be combinational from valids, last_grant and slot_free, and never high for both ports.
REQ-021 The granted operands and opcode SHALL drive the ALU combinationally; the result and flags SHALL load into the response register on the accepting edge (latency 1 cycle, rsp_valid high the next cycle).
REQ-022 rsp_valid SHALL remain high and all rsp_* fields stable until the cycle after rsp_valid && rsp_ready.
REQ-023 Simultaneous drain and accept (rsp_ready high with a new grant) SHALL replace the response without a bubble, giving full throughput of one op per cycle.
REQ-024 If a drain occurs with no new accept, rsp_valid SHALL drop to 0 on the next edge.
REQ-025 Requesters SHALL hold operands and opcode stable while valid && !ready; the block does not buffer them.

Reset
REQ-026 While resetn is 0: rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_overflow, rsp_carryout and rsp_err SHALL be 0, and last_grant SHALL be 1 so that port 0 wins the first tie.
REQ-027 Reset asserted mid-operation SHALL discard any pending response immediately, without waiting for a clock edge.

Configuration
REQ-028 Macro ALU_ARB_OPCHK_EN: when defined, a granted opcode that is not exactly one-hot SHALL still be accepted, with rsp_err=1 and rsp_result, rsp_zero, rsp_overflow and rsp_carryout all 0.
REQ-029 Without ALU_ARB_OPCHK_EN, no check SHALL be made, rsp_err SHALL be tied 0, and the raw ALU outputs SHALL pass through.

Structure
REQ-030 Shared package alu_pkg SHALL hold DATA_WIDTH, OP_WIDTH and the opcode bit-index constants OP_ADD..OP_LUI (0..11).
REQ-031 The datapath SHALL be the existing alu module, instantiated once as sub-module u_alu; arbitration and the response register SHALL be local to alu_arbiter.

Verification
REQ-032 Port 0 add with A=7, B=5, port 1 idle, rsp_ready=1 -> next cycle: rsp_valid=1, rsp_id=0, rsp_result=12, rsp_zero=0.
REQ-033 Both ports valid for 4 cycles, rsp_ready=1 -> accepted and responded ids 0,1,0,1, and rsp_valid high every cycle after the first.
REQ-034 Response pending with rsp_ready=0 for 3 cycles, both ports valid -> both readys 0, rsp_* unchanged; on rsp_ready=1 -> new grant goes to the port other than last_grant.
REQ-035 Port 1 add with A=0x7FFFFFFF, B=1 -> rsp_result=0x80000000, rsp_overflow=1, rsp_id=1; sub with A=B=0x5 -> rsp_zero=1.
REQ-036 ALUop=0x003 with macro defined -> rsp_err=1, rsp_result=0; without the macro -> rsp_err=0.
REQ-037 resetn driven low between clock edges while rsp_valid=1 -> rsp_valid=0 immediately; after release, a tie with both ports valid grants port 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and the two-port ALU arbiter.
// Holds the default widths, the one-hot opcode bit positions and a small
// flag bundle type used when carrying ALU flags around.
package alu_pkg;

  // Default operand/result width and one-hot opcode width.
  localparam int DATA_WIDTH = 32;
  localparam int OP_WIDTH   = 12;

  // Bit positions inside the one-hot ALUop vector.
  localparam int OP_ADD  = 0;
  localparam int OP_SUB  = 1;
  localparam int OP_AND  = 2;
  localparam int OP_OR   = 3;
  localparam int OP_NOR  = 4;
  localparam int OP_XOR  = 5;
  localparam int OP_SLT  = 6;
  localparam int OP_SLTU = 7;
  localparam int OP_SLL  = 8;
  localparam int OP_SRL  = 9;
  localparam int OP_SRA  = 10;
  localparam int OP_LUI  = 11;

  // ALU status flags travelling alongside a result.
  typedef struct packed {
    logic zero;
    logic overflow;
    logic carryout;
  } alu_flags_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU with a one-hot opcode.
// Each operation is computed in parallel and the opcode bits gate them onto
// the result through an AND-OR tree, so an opcode with several bits set
// yields the OR of the selected results (no priority).
// Shifts move B by the amount in the low bits of A; LUI places the low half
// of B in the upper half of the result.
// CarryOut is the adder carry for add and the borrow (A < B unsigned) for
// sub; Overflow is signed overflow for add/sub. Both are 0 for other ops.
module alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = alu_pkg::DATA_WIDTH,
  parameter int OP_WIDTH   = alu_pkg::OP_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic [OP_WIDTH-1:0]   ALUop,
  output logic [DATA_WIDTH-1:0] Result,
  output logic                  Overflow,
  output logic                  CarryOut,
  output logic                  Zero
);

  localparam int SHW  = $clog2(DATA_WIDTH);
  localparam int HALF = DATA_WIDTH / 2;

  logic [DATA_WIDTH:0]   add_sum;
  logic [DATA_WIDTH:0]   sub_sum;
  logic                  add_ovf;
  logic                  sub_ovf;
  logic                  less_s;
  logic                  less_u;
  logic [SHW-1:0]        shamt;
  logic [DATA_WIDTH-1:0] sll_res;
  logic [DATA_WIDTH-1:0] srl_res;
  logic [DATA_WIDTH-1:0] sra_res;
  logic [DATA_WIDTH-1:0] lui_res;

  // One extra bit on the sums captures the carry; subtraction is A + ~B + 1.
  assign add_sum = {1'b0, A} + {1'b0, B};
  assign sub_sum = {1'b0, A} + {1'b0, ~B} + {{DATA_WIDTH{1'b0}}, 1'b1};

  // Signed overflow: operands of matching (add) or differing (sub) sign
  // produce a result whose sign differs from A.
  assign add_ovf = (A[DATA_WIDTH-1] == B[DATA_WIDTH-1]) &&
                   (add_sum[DATA_WIDTH-1] != A[DATA_WIDTH-1]);
  assign sub_ovf = (A[DATA_WIDTH-1] != B[DATA_WIDTH-1]) &&
                   (sub_sum[DATA_WIDTH-1] != A[DATA_WIDTH-1]);

  // Comparisons reuse the subtractor: no carry out means a borrow.
  assign less_u = ~sub_sum[DATA_WIDTH];
  assign less_s = sub_sum[DATA_WIDTH-1] ^ sub_ovf;

  assign shamt   = A[SHW-1:0];
  assign sll_res = B << shamt;
  assign srl_res = B >> shamt;
  assign sra_res = $unsigned($signed(B) >>> shamt);
  assign lui_res = {B[HALF-1:0], {(DATA_WIDTH-HALF){1'b0}}};

  // AND-OR result select driven directly by the one-hot opcode bits.
  always_comb begin
    Result = '0;
    Result = Result | ({DATA_WIDTH{ALUop[OP_ADD]}}  & add_sum[DATA_WIDTH-1:0]);
    Result = Result | ({DATA_WIDTH{ALUop[OP_SUB]}}  & sub_sum[DATA_WIDTH-1:0]);
    Result = Result | ({DATA_WIDTH{ALUop[OP_AND]}}  & (A & B));
    Result = Result | ({DATA_WIDTH{ALUop[OP_OR]}}   & (A | B));
    Result = Result | ({DATA_WIDTH{ALUop[OP_NOR]}}  & ~(A | B));
    Result = Result | ({DATA_WIDTH{ALUop[OP_XOR]}}  & (A ^ B));
    Result = Result | ({DATA_WIDTH{ALUop[OP_SLT]}}  & {{(DATA_WIDTH-1){1'b0}}, less_s});
    Result = Result | ({DATA_WIDTH{ALUop[OP_SLTU]}} & {{(DATA_WIDTH-1){1'b0}}, less_u});
    Result = Result | ({DATA_WIDTH{ALUop[OP_SLL]}}  & sll_res);
    Result = Result | ({DATA_WIDTH{ALUop[OP_SRL]}}  & srl_res);
    Result = Result | ({DATA_WIDTH{ALUop[OP_SRA]}}  & sra_res);
    Result = Result | ({DATA_WIDTH{ALUop[OP_LUI]}}  & lui_res);
  end

  // Arithmetic flags only come from the adder/subtractor operations.
  always_comb begin
    Overflow = (ALUop[OP_ADD] & add_ovf) | (ALUop[OP_SUB] & sub_ovf);
    CarryOut = (ALUop[OP_ADD] & add_sum[DATA_WIDTH]) | (ALUop[OP_SUB] & less_u);
    Zero     = ~|Result;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end that time-shares a single ALU.
// Round-robin grant between req0/req1, one accept per cycle, and a one-deep
// response register (rsp_*) that can be drained and refilled on the same
// edge for full throughput.
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; a requester holds its fields stable while valid && !ready, and
// the response holds its fields stable while rsp_valid && !rsp_ready.
// Optional build macro ALU_ARB_OPCHK_EN: flags granted opcodes that are not
// exactly one-hot with rsp_err=1 and a zeroed result/flags. Without it the
// raw ALU outputs pass through and rsp_err is tied low.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = alu_pkg::DATA_WIDTH,
  parameter int OP_WIDTH   = alu_pkg::OP_WIDTH
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DATA_WIDTH-1:0] req0_A,
  input  logic [DATA_WIDTH-1:0] req0_B,
  input  logic [OP_WIDTH-1:0]   req0_ALUop,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DATA_WIDTH-1:0] req1_A,
  input  logic [DATA_WIDTH-1:0] req1_B,
  input  logic [OP_WIDTH-1:0]   req1_ALUop,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic                  rsp_zero,
  output logic                  rsp_overflow,
  output logic                  rsp_carryout,
  output logic                  rsp_err
);

  logic                  slot_free;
  logic                  last_grant;
  logic                  grant0;
  logic                  grant1;
  logic                  accept;
  logic                  sel_port;

  logic [DATA_WIDTH-1:0] alu_a;
  logic [DATA_WIDTH-1:0] alu_b;
  logic [OP_WIDTH-1:0]   alu_op;
  logic [DATA_WIDTH-1:0] alu_result;
  alu_flags_t            alu_flags;

  logic [DATA_WIDTH-1:0] nxt_result;
  alu_flags_t            nxt_flags;

  // The response slot can take a new result if it is empty or being drained.
  assign slot_free = !rsp_valid || rsp_ready;

  // Round-robin grant: a lone requester always wins, a tie goes to the
  // port that did not win last time.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (slot_free) begin
      if (req0_valid && req1_valid) begin
        grant0 = last_grant;
        grant1 = !last_grant;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign accept     = grant0 || grant1;
  assign sel_port   = grant1;

  // Steer the granted port's operands and opcode into the shared ALU.
  always_comb begin
    alu_a  = sel_port ? req1_A     : req0_A;
    alu_b  = sel_port ? req1_B     : req0_B;
    alu_op = sel_port ? req1_ALUop : req0_ALUop;
  end

  alu #(
    .DATA_WIDTH (DATA_WIDTH),
    .OP_WIDTH   (OP_WIDTH)
  ) u_alu (
    .A        (alu_a),
    .B        (alu_b),
    .ALUop    (alu_op),
    .Result   (alu_result),
    .Overflow (alu_flags.overflow),
    .CarryOut (alu_flags.carryout),
    .Zero     (alu_flags.zero)
  );

`ifdef ALU_ARB_OPCHK_EN
  logic op_bad;
  logic rsp_err_q;

  // An opcode is legal only if exactly one bit is set.
  assign op_bad = (alu_op == '0) || ((alu_op & (alu_op - 1'b1)) != '0);

  // Illegal opcodes still complete, but with a zeroed result and flags.
  always_comb begin
    nxt_result = op_bad ? '0 : alu_result;
    nxt_flags  = op_bad ? '0 : alu_flags;
  end

  // Error bit travels with the response register contents.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rsp_err_q <= 1'b0;
    end else if (accept) begin
      rsp_err_q <= op_bad;
    end
  end

  assign rsp_err = rsp_err_q;
`else
  // No opcode screening: the ALU outputs load as they are.
  always_comb begin
    nxt_result = alu_result;
    nxt_flags  = alu_flags;
  end

  assign rsp_err = 1'b0;
`endif

  // Response register: load on accept, clear valid on a drain with no
  // replacement, otherwise hold.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_result   <= '0;
      rsp_zero     <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_carryout <= 1'b0;
    end else if (accept) begin
      rsp_valid    <= 1'b1;
      rsp_id       <= sel_port;
      rsp_result   <= nxt_result;
      rsp_zero     <= nxt_flags.zero;
      rsp_overflow <= nxt_flags.overflow;
      rsp_carryout <= nxt_flags.carryout;
    end else if (rsp_ready) begin
      rsp_valid    <= 1'b0;
    end
  end

  // Round-robin pointer: remembers the last accepted port; reset value 1
  // lets port 0 win the first tie.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= sel_port;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed vectors with literal expectations plus a
// transaction-level model (queue of pending responses and a round-robin
// pointer) compared against the DUT on every falling edge.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int W   = 32;
  localparam int OPW = 12;

  logic          clk;
  logic          resetn;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [W-1:0]  req0_A, req0_B, req1_A, req1_B;
  logic [OPW-1:0] req0_ALUop, req1_ALUop;
  logic          rsp_valid, rsp_ready, rsp_id;
  logic [W-1:0]  rsp_result;
  logic          rsp_zero, rsp_overflow, rsp_carryout, rsp_err;

  int checks   = 0;
  int failures = 0;
  logic run = 1'b0;

  alu_arbiter #(.DATA_WIDTH(W), .OP_WIDTH(OPW)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_A       (req0_A),
    .req0_B       (req0_B),
    .req0_ALUop   (req0_ALUop),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_A       (req1_A),
    .req1_B       (req1_B),
    .req1_ALUop   (req1_ALUop),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_result   (rsp_result),
    .rsp_zero     (rsp_zero),
    .rsp_overflow (rsp_overflow),
    .rsp_carryout (rsp_carryout),
    .rsp_err      (rsp_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking helper ----------------
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic         id;
    logic [W-1:0] result;
    logic         zero;
    logic         ovf;
    logic         cout;
    logic         err;
    logic         chk;   // result/flags are defined for this opcode
  } exp_t;

  exp_t exp_q[$];
  logic m_last;

  function automatic logic sov(input longint s);
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  function automatic exp_t model_op(input logic id, input logic [W-1:0] a,
                                    input logic [W-1:0] b, input logic [OPW-1:0] op);
    exp_t e;
    logic [W:0] wide;
    e.id = id; e.err = 1'b0; e.chk = 1'b1; e.ovf = 1'b0; e.cout = 1'b0;
    e.result = '0;
    case (op)
      12'h001: begin
        wide = {1'b0, a} + {1'b0, b};
        e.result = wide[W-1:0];
        e.cout = wide[W];
        e.ovf = sov(longint'($signed(a)) + longint'($signed(b)));
      end
      12'h002: begin
        e.result = a - b;
        e.cout = (a < b);
        e.ovf = sov(longint'($signed(a)) - longint'($signed(b)));
      end
      12'h004: e.result = a & b;
      12'h008: e.result = a | b;
      12'h010: e.result = ~(a | b);
      12'h020: e.result = a ^ b;
      12'h040: e.result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      12'h080: e.result = (a < b) ? 32'd1 : 32'd0;
      12'h100: e.result = b << a[4:0];
      12'h200: e.result = b >> a[4:0];
      12'h400: e.result = $unsigned($signed(b) >>> a[4:0]);
      12'h800: e.result = {b[15:0], 16'h0000};
      default: begin
`ifdef ALU_ARB_OPCHK_EN
        e.err = 1'b1;
`else
        e.chk = 1'b0;
`endif
      end
    endcase
    e.zero = (e.err || !e.chk) ? 1'b0 : (e.result == '0);
    return e;
  endfunction

  // Which port the model expects to be accepted right now (-1 = none).
  function automatic int exp_grant();
    logic free;
    free = (exp_q.size() == 0) || rsp_ready;
    if (!free) return -1;
    if (req0_valid && req1_valid) return m_last ? 0 : 1;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  // Model update on each edge; reset empties the response queue at once.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      exp_q.delete();
      m_last = 1'b1;
    end else begin : model_step
      int g;
      g = exp_grant();
      if (exp_q.size() != 0 && rsp_ready) void'(exp_q.pop_front());
      if (g == 0) begin
        exp_q.push_back(model_op(1'b0, req0_A, req0_B, req0_ALUop));
        m_last = 1'b0;
      end else if (g == 1) begin
        exp_q.push_back(model_op(1'b1, req1_A, req1_B, req1_ALUop));
        m_last = 1'b1;
      end
    end
  end

  // Compare process: every falling edge out of reset.
  always @(negedge clk) begin
    if (run && resetn) begin : cmp
      int g;
      g = exp_grant();
      check("m_req0_ready", req0_ready, (g == 0));
      check("m_req1_ready", req1_ready, (g == 1));
      check("m_rsp_valid", rsp_valid, (exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        check("m_rsp_id", rsp_id, exp_q[0].id);
        check("m_rsp_err", rsp_err, exp_q[0].err);
        if (exp_q[0].chk) begin
          check("m_rsp_result", rsp_result, exp_q[0].result);
          check("m_rsp_zero", rsp_zero, exp_q[0].zero);
          check("m_rsp_overflow", rsp_overflow, exp_q[0].ovf);
          check("m_rsp_carryout", rsp_carryout, exp_q[0].cout);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic set_port(input logic port, input logic [OPW-1:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b);
    if (port) begin
      req1_valid = 1'b1; req1_ALUop = op; req1_A = a; req1_B = b;
    end else begin
      req0_valid = 1'b1; req0_ALUop = op; req0_A = a; req0_B = b;
    end
  endtask

  // One op on one port with the other idle; response visible on return.
  task automatic issue(input logic port, input logic [OPW-1:0] op,
                       input logic [W-1:0] a, input logic [W-1:0] b, input logic rr);
    idle_inputs();
    rsp_ready = rr;
    set_port(port, op, a, b);
    step();
    idle_inputs();
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic           port;
    logic [OPW-1:0] op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [W-1:0]   res;
    logic           z;
    logic           o;
    logic           c;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int exp_ids[4];
    logic g1;
    exp_ids = '{0, 1, 0, 1};

    vecs.push_back('{1'b1, 12'h001, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 12'h002, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 12'h001, 32'h0000_0007, 32'h0000_0005, 32'h0000_000C, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 12'h001, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 12'h002, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 12'h002, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 12'h004, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 12'h008, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 12'h010, 32'h0F0F_0F0F, 32'hF0F0_0000, 32'h0000_F0F0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 12'h020, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 12'h040, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 12'h040, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 12'h080, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 12'h100, 32'h0000_0004, 32'h0000_0003, 32'h0000_0030, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 12'h200, 32'h0000_0008, 32'h8000_0000, 32'h0080_0000, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 12'h400, 32'h0000_0008, 32'h8000_0000, 32'hFF80_0000, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 12'h800, 32'h0000_DEAD, 32'h0000_1234, 32'h1234_0000, 1'b0, 1'b0, 1'b0});

    req0_A = '0; req0_B = '0; req0_ALUop = '0;
    req1_A = '0; req1_B = '0; req1_ALUop = '0;
    idle_inputs();
    rsp_ready = 1'b0;
    resetn = 1'b0;

    // Reset state
    repeat (2) step();
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_id", rsp_id, 1'b0);
    check("rst_rsp_result", rsp_result, 32'h0);
    check("rst_rsp_zero", rsp_zero, 1'b0);
    check("rst_rsp_overflow", rsp_overflow, 1'b0);
    check("rst_rsp_carryout", rsp_carryout, 1'b0);
    check("rst_rsp_err", rsp_err, 1'b0);
    resetn = 1'b1;
    run = 1'b1;
    step();

    // Both ports valid for 4 cycles: alternate 0,1,0,1 starting at port 0
    rsp_ready = 1'b1;
    set_port(1'b0, 12'h001, 32'd1, 32'd1);
    set_port(1'b1, 12'h001, 32'd2, 32'd2);
    for (int i = 0; i < 4; i++) begin
      #1;
      g1 = req1_ready;
      check("tie_one_ready", {31'b0, req0_ready} + {31'b0, req1_ready}, 32'd1);
      check("tie_grant", g1, exp_ids[i][0]);
      step();
      check("tie_rsp_valid", rsp_valid, 1'b1);
      check("tie_rsp_id", rsp_id, exp_ids[i][0]);
      check("tie_rsp_result", rsp_result, exp_ids[i][0] ? 32'd4 : 32'd2);
    end
    idle_inputs();
    step();
    check("drain_rsp_valid", rsp_valid, 1'b0);

    // Backpressure: response held 3 cycles while both ports wait
    issue(1'b0, 12'h020, 32'h0000_1234, 32'h0000_00FF, 1'b0);
    set_port(1'b0, 12'h008, 32'h1, 32'h2);
    set_port(1'b1, 12'h004, 32'hF, 32'h3);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_req0_ready", req0_ready, 1'b0);
      check("bp_req1_ready", req1_ready, 1'b0);
      step();
      check("bp_rsp_valid", rsp_valid, 1'b1);
      check("bp_rsp_id", rsp_id, 1'b0);
      check("bp_rsp_result", rsp_result, 32'h0000_12CB);
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_release_req0", req0_ready, 1'b0);
    check("bp_release_req1", req1_ready, 1'b1);
    step();
    check("bp_new_id", rsp_id, 1'b1);
    check("bp_new_result", rsp_result, 32'h0000_0003);
    idle_inputs();
    step();

    // Directed ALU vectors, one at a time, response taken immediately
    foreach (vecs[k]) begin
      issue(vecs[k].port, vecs[k].op, vecs[k].a, vecs[k].b, 1'b1);
      check("vec_rsp_valid", rsp_valid, 1'b1);
      check("vec_rsp_id", rsp_id, vecs[k].port);
      check("vec_rsp_result", rsp_result, vecs[k].res);
      check("vec_rsp_zero", rsp_zero, vecs[k].z);
      check("vec_rsp_overflow", rsp_overflow, vecs[k].o);
      check("vec_rsp_carryout", rsp_carryout, vecs[k].c);
    end
    step();

    // Non one-hot opcode
    issue(1'b0, 12'h003, 32'd7, 32'd5, 1'b1);
`ifdef ALU_ARB_OPCHK_EN
    check("bad_op_err", rsp_err, 1'b1);
    check("bad_op_result", rsp_result, 32'h0);
    check("bad_op_zero", rsp_zero, 1'b0);
`else
    check("bad_op_err", rsp_err, 1'b0);
`endif
    check("bad_op_valid", rsp_valid, 1'b1);
    step();

    // Asynchronous reset between edges with a response pending
    issue(1'b1, 12'h001, 32'd1, 32'd2, 1'b0);
    check("ar_pending_valid", rsp_valid, 1'b1);
    #2;
    resetn = 1'b0;
    #1;
    check("ar_rsp_valid", rsp_valid, 1'b0);
    check("ar_rsp_result", rsp_result, 32'h0);
    check("ar_rsp_id", rsp_id, 1'b0);
    step();
    resetn = 1'b1;
    rsp_ready = 1'b1;
    set_port(1'b0, 12'h001, 32'd10, 32'd20);
    set_port(1'b1, 12'h001, 32'd30, 32'd40);
    #1;
    check("ar_tie_req0", req0_ready, 1'b1);
    check("ar_tie_req1", req1_ready, 1'b0);
    step();
    check("ar_tie_id", rsp_id, 1'b0);
    check("ar_tie_result", rsp_result, 32'd30);
    idle_inputs();
    step();
    step();

    run = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
